axi_node_cfg_sequencer: RTL and testbench
=========================================

Name: axi_node_cfg_sequencer

Overview:
Configuration controller for the AXI node's address map (cfg_START_ADDR / cfg_END_ADDR / cfg_valid_rule).
- Accepts rule writes into a shadow copy.
- On commit, blocks new AW/AR on every node slave port and waits until all outstanding transactions drain.
- Copies shadow to active in one cycle, then releases traffic.
- Also acts as a per-slave-port outstanding-transaction limiter. Sits beside the node wrapper; the wrapper gates AW/AR valid/ready with the block outputs.

Parameters:
- N_MASTER_PORT, 8, node master ports (address-rule columns).
- N_SLAVE_PORT, 4, node slave ports (monitored/gated).
- N_REGION, 4, regions per master port.
- MAX_OUTSTANDING, 16, per-port, per-direction outstanding limit (>=1).
- DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN; 0 = no timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_valid_i  in  1  rule-write request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_region_i  in  $clog2(N_REGION)  target region index
- req_master_i  in  $clog2(N_MASTER_PORT)  target master-port index
- req_start_i  in  32  start address
- req_end_i  in  32  end address
- req_rule_valid_i  in  1  rule enable bit
- req_commit_i  in  1  1 = apply shadow after this write
- slv_aw_fire_i  in  N_SLAVE_PORT  AW handshake per slave port
- slv_b_fire_i  in  N_SLAVE_PORT  B handshake
- slv_ar_fire_i  in  N_SLAVE_PORT  AR handshake
- slv_rlast_fire_i  in  N_SLAVE_PORT  R handshake with RLAST
- slv_aw_block_o  out  N_SLAVE_PORT  registered; 1 = suppress AW
- slv_ar_block_o  out  N_SLAVE_PORT  registered; 1 = suppress AR
- cfg_START_ADDR_o  out  N_REGION*N_MASTER_PORT*32  active start addresses
- cfg_END_ADDR_o  out  N_REGION*N_MASTER_PORT*32  active end addresses
- cfg_valid_rule_o  out  N_REGION*N_MASTER_PORT  active rule enables
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on drain abort
- err_o  out  1  sticky underflow flag; cleared only by reset

Behaviour:
- Reset: all shadow and active arrays 0; counters 0; blocks 0; busy_o, timeout_o, err_o 0; state IDLE.
- Counters: per port, wr_cnt and rd_cnt, width $clog2(MAX_OUTSTANDING+1).
  - AW fire: +1; B fire: -1; both in the same cycle: unchanged.
  - rd_cnt: same rule with AR / RLAST.
  - Decrement at 0: stays 0, sets err_o.
  - Increment at MAX_OUTSTANDING: saturates (wrapper contract violation).
- Block outputs, registered (next-state based, so the block appears the cycle after the condition):
  - slv_aw_block_o[p] = (next state in BLOCK/DRAIN/APPLY) | (next wr_cnt[p] == MAX_OUTSTANDING).
  - slv_ar_block_o[p] likewise with rd_cnt.
- FSM:
  - IDLE: req_ready_o=1, all other states 0. On accept, write shadow[region][master] = {start, end, rule_valid}. If commit=1, go BLOCK; else stay IDLE.
  - BLOCK (1 cycle): blocks are now asserted; absorbs any fire that completed the previous cycle. Go DRAIN.
  - DRAIN: when all wr_cnt and rd_cnt == 0, go APPLY. Timeout counter increments each DRAIN cycle; reaching DRAIN_TIMEOUT (if nonzero) -> timeout_o=1, go IDLE, shadow retained, active unchanged.
  - APPLY (1 cycle): active <= shadow, all entries at once. Go IDLE; blocks deassert the following cycle unless a port is at its limit.
- A commit with identical shadow and active still runs the full sequence.
- Request indices out of range (non-power-of-2 sizes): write ignored, commit still honoured.
- Config outputs change only in APPLY, never mid-drain.
- Reset mid-sequence: immediate return to reset values; active config lost (zero).

Decomposition:
- Shared package axi_node_cfg_pkg holds:
  - typedef cfg_rule_t {start, end, valid};
  - state enum {IDLE, BLOCK, DRAIN, APPLY};
  - function cnt_width(max).
- One sub-module, axi_node_outstanding_cnt: one up/down counter with saturation, underflow error and at-max flag. Instantiated 2*N_SLAVE_PORT times.

Test Plan:
- Reset, then write region1/master2 start=0x1000_0000, end=0x1FFF_FFFF, valid=1, commit=0 -> cfg outputs stay 0 and busy_o=0; follow with a commit write to region0/master0 -> both rules appear together in the APPLY cycle; busy_o high exactly 3 cycles (BLOCK, DRAIN, APPLY) with no traffic.
- 3 AW fires on port0, then commit -> blocks asserted; APPLY occurs only the cycle after the 3rd B fire; no config change before.
- Commit with 1 AR outstanding and no RLAST, DRAIN_TIMEOUT=8 -> timeout_o pulses after 8 DRAIN cycles, cfg unchanged, blocks released the next cycle.
- 16 AR fires on port2 without RLAST -> slv_ar_block_o[2]=1 the cycle after the 16th; one RLAST -> deasserts the cycle after.
- Same-cycle AW+B fires on port1 with wr_cnt=1 -> count stays 1; B fire with wr_cnt=0 -> err_o=1 and stays set.
- Assert rst_n low during DRAIN -> all outputs 0 immediately; after release, req_ready_o=1.

Source files
------------

// File: rtl/axi_node_cfg_pkg.sv
// Shared types for the AXI node configuration sequencer: one address rule,
// the sequencer state encoding and the outstanding-counter width helper.
package axi_node_cfg_pkg;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
        logic        valid;
    } cfg_rule_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLOCK,
        ST_DRAIN,
        ST_APPLY
    } state_e;

    // Width able to hold 0..max inclusive, never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/axi_node_outstanding_cnt.sv
// One per-port, per-direction outstanding-transaction counter: saturating
// increment, floor-at-zero decrement that flags underflow, look-ahead flags.
module axi_node_outstanding_cnt
    import axi_node_cfg_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CW              = cnt_width(MAX_OUTSTANDING)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_next_o,
    output logic at_max_next_o,
    output logic underflow_o
);

    localparam logic [CW-1:0] MAX_VAL = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q != MAX_VAL) cnt_d = cnt_q + ONE;
            end
            2'b01: begin
                if (cnt_q == '0) underflow_o = 1'b1;
                else             cnt_d       = cnt_q - ONE;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_next_o   = (cnt_d == '0);
    assign at_max_next_o = (cnt_d == MAX_VAL);

endmodule

// File: rtl/axi_node_cfg_sequencer.sv
// Address-map configuration sequencer for the AXI node: shadows rule writes,
// quiesces all slave ports on commit, swaps shadow into active atomically.
module axi_node_cfg_sequencer
    import axi_node_cfg_pkg::*;
#(
    parameter int N_MASTER_PORT   = 8,
    parameter int N_SLAVE_PORT    = 4,
    parameter int N_REGION        = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [$clog2(N_REGION)-1:0]          req_region_i,
    input  logic [$clog2(N_MASTER_PORT)-1:0]     req_master_i,
    input  logic [31:0]                          req_start_i,
    input  logic [31:0]                          req_end_i,
    input  logic                                 req_rule_valid_i,
    input  logic                                 req_commit_i,
    input  logic [N_SLAVE_PORT-1:0]              slv_aw_fire_i,
    input  logic [N_SLAVE_PORT-1:0]              slv_b_fire_i,
    input  logic [N_SLAVE_PORT-1:0]              slv_ar_fire_i,
    input  logic [N_SLAVE_PORT-1:0]              slv_rlast_fire_i,
    output logic [N_SLAVE_PORT-1:0]              slv_aw_block_o,
    output logic [N_SLAVE_PORT-1:0]              slv_ar_block_o,
    output logic [N_REGION*N_MASTER_PORT*32-1:0] cfg_START_ADDR_o,
    output logic [N_REGION*N_MASTER_PORT*32-1:0] cfg_END_ADDR_o,
    output logic [N_REGION*N_MASTER_PORT-1:0]    cfg_valid_rule_o,
    output logic                                 busy_o,
    output logic                                 timeout_o,
    output logic                                 err_o
);

    localparam int            N_ENT    = N_REGION * N_MASTER_PORT;
    localparam int            IW       = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int            TW       = cnt_width(DRAIN_TIMEOUT);
    localparam bit            TMO_EN   = (DRAIN_TIMEOUT != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);

    state_e                  state_q;
    logic                    ready_q;
    logic                    timeout_q;
    logic                    err_q;
    logic [TW-1:0]           tmo_q;
    logic [N_SLAVE_PORT-1:0] aw_block_q;
    logic [N_SLAVE_PORT-1:0] ar_block_q;

    cfg_rule_t shadow_q [N_ENT];
    cfg_rule_t active_q [N_ENT];

    logic [N_SLAVE_PORT-1:0] wr_zero_d, wr_max_d, wr_uflow;
    logic [N_SLAVE_PORT-1:0] rd_zero_d, rd_max_d, rd_uflow;

    logic          accept;
    logic          in_range;
    logic [IW-1:0] wr_idx;
    logic          drained;
    logic          tmo_hit;
    logic          apply_go;

    assign accept   = req_valid_i & ready_q;
    assign in_range = (32'(req_region_i) < 32'(N_REGION)) &&
                      (32'(req_master_i) < 32'(N_MASTER_PORT));
    assign wr_idx   = IW'(32'(req_region_i) * N_MASTER_PORT + 32'(req_master_i));

    // Drain completes on the cycle the last response lands, not one later.
    assign drained  = (&wr_zero_d) & (&rd_zero_d);
    assign tmo_hit  = TMO_EN && (tmo_q == TMO_LAST);
    assign apply_go = (state_q == ST_DRAIN) && drained;

    for (genvar p = 0; p < N_SLAVE_PORT; p++) begin : g_port
        axi_node_outstanding_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) u_wr_cnt (
            .clk           (clk),
            .rst_n         (rst_n),
            .inc_i         (slv_aw_fire_i[p]),
            .dec_i         (slv_b_fire_i[p]),
            .zero_next_o   (wr_zero_d[p]),
            .at_max_next_o (wr_max_d[p]),
            .underflow_o   (wr_uflow[p])
        );

        axi_node_outstanding_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) u_rd_cnt (
            .clk           (clk),
            .rst_n         (rst_n),
            .inc_i         (slv_ar_fire_i[p]),
            .dec_i         (slv_rlast_fire_i[p]),
            .zero_next_o   (rd_zero_d[p]),
            .at_max_next_o (rd_max_d[p]),
            .underflow_o   (rd_uflow[p])
        );
    end

    // Gating outputs are computed from the next state, so the default keeps
    // every port blocked and only transitions into IDLE release them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
            tmo_q      <= '0;
            aw_block_q <= '0;
            ar_block_q <= '0;
        end else begin
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
            aw_block_q <= '1;
            ar_block_q <= '1;
            case (state_q)
                ST_IDLE: begin
                    if (accept && req_commit_i) begin
                        state_q <= ST_BLOCK;
                    end else begin
                        ready_q    <= 1'b1;
                        aw_block_q <= wr_max_d;
                        ar_block_q <= rd_max_d;
                    end
                end
                ST_BLOCK: begin
                    tmo_q   <= '0;
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state_q <= ST_APPLY;
                    end else if (tmo_hit) begin
                        state_q    <= ST_IDLE;
                        timeout_q  <= 1'b1;
                        ready_q    <= 1'b1;
                        aw_block_q <= wr_max_d;
                        ar_block_q <= rd_max_d;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_APPLY: begin
                    state_q    <= ST_IDLE;
                    ready_q    <= 1'b1;
                    aw_block_q <= wr_max_d;
                    ar_block_q <= rd_max_d;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the rule arrays are reset explicitly because a reset must leave the node with an all-zero address map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (accept && in_range) begin
                shadow_q[wr_idx] <= cfg_rule_t'{start_addr: req_start_i,
                                                end_addr:   req_end_i,
                                                valid:      req_rule_valid_i};
            end
            if (apply_go) active_q <= shadow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | (|wr_uflow) | (|rd_uflow);
    end

    for (genvar i = 0; i < N_ENT; i++) begin : g_cfg_out
        assign cfg_START_ADDR_o[i*32 +: 32] = active_q[i].start_addr;
        assign cfg_END_ADDR_o[i*32 +: 32]   = active_q[i].end_addr;
        assign cfg_valid_rule_o[i]          = active_q[i].valid;
    end

    assign req_ready_o    = ready_q;
    assign slv_aw_block_o = aw_block_q;
    assign slv_ar_block_o = ar_block_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign timeout_o      = timeout_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_axi_node_cfg_sequencer.sv
// Self-checking bench for axi_node_cfg_sequencer: commit expectations are
// queued when a commit is sent and compared when the sequence completes.
module tb_axi_node_cfg_sequencer;

    localparam int NM   = 8;
    localparam int NS   = 4;
    localparam int NR   = 4;
    localparam int NE   = NM * NR;
    localparam int TMO  = 8;
    localparam int MAXO = 16;

    typedef struct packed {
        logic [NE*32-1:0] st;
        logic [NE*32-1:0] en;
        logic [NE-1:0]    v;
    } cfg_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                req_valid_i = 1'b0;
    logic                req_ready_o;
    logic [1:0]          req_region_i = '0;
    logic [2:0]          req_master_i = '0;
    logic [31:0]         req_start_i = '0;
    logic [31:0]         req_end_i = '0;
    logic                req_rule_valid_i = 1'b0;
    logic                req_commit_i = 1'b0;
    logic [NS-1:0]       slv_aw_fire_i = '0;
    logic [NS-1:0]       slv_b_fire_i = '0;
    logic [NS-1:0]       slv_ar_fire_i = '0;
    logic [NS-1:0]       slv_rlast_fire_i = '0;
    logic [NS-1:0]       slv_aw_block_o;
    logic [NS-1:0]       slv_ar_block_o;
    logic [NE*32-1:0]    cfg_START_ADDR_o;
    logic [NE*32-1:0]    cfg_END_ADDR_o;
    logic [NE-1:0]       cfg_valid_rule_o;
    logic                busy_o;
    logic                timeout_o;
    logic                err_o;

    int   tests = 0;
    int   fails = 0;
    cfg_t sh    = '0;
    cfg_t act   = '0;
    cfg_t exp_q [$];

    axi_node_cfg_sequencer #(
        .N_MASTER_PORT   (NM),
        .N_SLAVE_PORT    (NS),
        .N_REGION        (NR),
        .MAX_OUTSTANDING (MAXO),
        .DRAIN_TIMEOUT   (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_region_i     (req_region_i),
        .req_master_i     (req_master_i),
        .req_start_i      (req_start_i),
        .req_end_i        (req_end_i),
        .req_rule_valid_i (req_rule_valid_i),
        .req_commit_i     (req_commit_i),
        .slv_aw_fire_i    (slv_aw_fire_i),
        .slv_b_fire_i     (slv_b_fire_i),
        .slv_ar_fire_i    (slv_ar_fire_i),
        .slv_rlast_fire_i (slv_rlast_fire_i),
        .slv_aw_block_o   (slv_aw_block_o),
        .slv_ar_block_o   (slv_ar_block_o),
        .cfg_START_ADDR_o (cfg_START_ADDR_o),
        .cfg_END_ADDR_o   (cfg_END_ADDR_o),
        .cfg_valid_rule_o (cfg_valid_rule_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    function automatic cfg_t cur_cfg();
        cfg_t c;
        c.st = cfg_START_ADDR_o;
        c.en = cfg_END_ADDR_o;
        c.v  = cfg_valid_rule_o;
        return c;
    endfunction

    task automatic report_cfg(input string name, input cfg_t got, input cfg_t want);
        int k;
        k = 0;
        for (int i = 0; i < NE; i++) begin
            if (got.st[i*32 +: 32] !== want.st[i*32 +: 32] ||
                got.en[i*32 +: 32] !== want.en[i*32 +: 32] ||
                got.v[i] !== want.v[i]) begin
                k = i;
                break;
            end
        end
        $display("FAIL %s: entry %0d got start=%h end=%h v=%b, want start=%h end=%h v=%b",
                 name, k, got.st[k*32 +: 32], got.en[k*32 +: 32], got.v[k],
                 want.st[k*32 +: 32], want.en[k*32 +: 32], want.v[k]);
    endtask

    // Drives one request across one rising edge; called and returns just after a falling edge.
    task automatic send_req(input int r, input int m, input logic [31:0] s, input logic [31:0] e,
                            input logic v, input logic c, input logic expect_apply);
        tests++;
        if (req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL req_ready before request: got %b want 1", req_ready_o);
        end
        req_region_i     = r[1:0];
        req_master_i     = m[2:0];
        req_start_i      = s;
        req_end_i        = e;
        req_rule_valid_i = v;
        req_commit_i     = c;
        req_valid_i      = 1'b1;
        @(negedge clk);
        req_valid_i  = 1'b0;
        req_commit_i = 1'b0;
        sh.st[(r*NM+m)*32 +: 32] = s;
        sh.en[(r*NM+m)*32 +: 32] = e;
        sh.v[r*NM+m]             = v;
        if (c) exp_q.push_back(expect_apply ? sh : act);
    endtask

    // Follows a commit until busy drops; config may change only in the final busy cycle.
    task automatic wait_sequence(output int nbusy, output logic tmo_seen);
        cfg_t prev, cur, exp;
        logic changed;
        nbusy   = 0;
        changed = 1'b0;
        prev    = act;
        while (busy_o === 1'b1 && nbusy < 64) begin
            cur = cur_cfg();
            tests++;
            if (changed) begin
                fails++;
                $display("FAIL cfg changed before last busy cycle: busy cycle %0d", nbusy);
            end
            if (cur !== prev) changed = 1'b1;
            tests++;
            if (slv_aw_block_o !== '1 || slv_ar_block_o !== '1) begin
                fails++;
                $display("FAIL blocks during sequence: aw=%b ar=%b want 1111/1111",
                         slv_aw_block_o, slv_ar_block_o);
            end
            prev = cur;
            nbusy++;
            @(negedge clk);
        end
        tests++;
        if (nbusy >= 64) begin
            fails++;
            $display("FAIL sequence bound: busy still %b after %0d cycles", busy_o, nbusy);
        end
        tmo_seen = timeout_o;
        cur = cur_cfg();
        tests++;
        if (cur !== prev) begin
            fails++;
            report_cfg("cfg changed after sequence", cur, prev);
        end
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: no expected config queued, got none want 1");
        end else begin
            exp = exp_q.pop_front();
            tests++;
            if (cur !== exp) begin
                fails++;
                report_cfg("applied config", cur, exp);
            end
            act = exp;
        end
    endtask

    task automatic check_idle_cfg(input string name);
        tests++;
        if (busy_o !== 1'b1 && cur_cfg() === act) return;
        fails++;
        if (busy_o === 1'b1) $display("FAIL %s busy: got %b want 0", name, busy_o);
        else                 report_cfg(name, cur_cfg(), act);
    endtask

    task automatic check_busy_cfg(input string name);
        tests++;
        if (busy_o !== 1'b1 || cur_cfg() !== act) begin
            fails++;
            $display("FAIL %s: busy=%b want 1, cfg_valid=%h want %h", name, busy_o, cfg_valid_rule_o, act.v);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (busy_o !== 1'b0 || req_ready_o !== 1'b0 || slv_aw_block_o !== '0 || slv_ar_block_o !== '0 ||
            timeout_o !== 1'b0 || err_o !== 1'b0 || cur_cfg() !== cfg_t'(0)) begin
            fails++;
            $display("FAIL %s: busy=%b rdy=%b awb=%b arb=%b tmo=%b err=%b cfgv=%h want all 0",
                     name, busy_o, req_ready_o, slv_aw_block_o, slv_ar_block_o, timeout_o, err_o, cfg_valid_rule_o);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset values");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL ready after reset: rdy=%b busy=%b want 1/0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_shadow_commit();
        int   n;
        logic t;
        send_req(1, 2, 32'h1000_0000, 32'h1FFF_FFFF, 1'b1, 1'b0, 1'b1);
        check_idle_cfg("shadow write without commit");
        send_req(0, 0, 32'h2000_0000, 32'h2FFF_FFFF, 1'b1, 1'b1, 1'b1);
        wait_sequence(n, t);
        tests++;
        if (n != 3 || t !== 1'b0) begin
            fails++;
            $display("FAIL idle commit length: busy=%0d tmo=%b want 3/0", n, t);
        end
        tests++;
        if (slv_aw_block_o !== '0 || slv_ar_block_o !== '0 || req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL release after apply: aw=%b ar=%b rdy=%b want 0/0/1", slv_aw_block_o, slv_ar_block_o, req_ready_o);
        end
    endtask

    task automatic test_drain_aw();
        int   n;
        logic t;
        slv_aw_fire_i[0] = 1'b1;
        repeat (3) @(negedge clk);
        slv_aw_fire_i[0] = 1'b0;
        send_req(3, 7, 32'h7000_0000, 32'h7000_FFFF, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check_busy_cfg("drain entered, cfg held");
        for (int k = 0; k < 3; k++) begin
            slv_b_fire_i[0] = 1'b1;
            @(negedge clk);
            slv_b_fire_i[0] = 1'b0;
            if (k < 2) begin
                check_busy_cfg("drain after B fire");
                @(negedge clk);
                check_busy_cfg("drain gap cycle");
            end
        end
        wait_sequence(n, t);
        tests++;
        if (n != 1 || t !== 1'b0) begin
            fails++;
            $display("FAIL apply after last B: busy=%0d tmo=%b want 1/0", n, t);
        end
    endtask

    task automatic test_timeout();
        int   n;
        logic t;
        slv_ar_fire_i[1] = 1'b1;
        @(negedge clk);
        slv_ar_fire_i[1] = 1'b0;
        send_req(2, 5, 32'h5000_0000, 32'h5FFF_FFFF, 1'b1, 1'b1, 1'b0);
        wait_sequence(n, t);
        tests++;
        if (n != 1 + TMO || t !== 1'b1) begin
            fails++;
            $display("FAIL drain timeout: busy=%0d tmo=%b want %0d/1", n, t, 1 + TMO);
        end
        tests++;
        if (slv_aw_block_o !== '0 || slv_ar_block_o !== '0) begin
            fails++;
            $display("FAIL release after timeout: aw=%b ar=%b want 0/0", slv_aw_block_o, slv_ar_block_o);
        end
        slv_rlast_fire_i[1] = 1'b1;
        @(negedge clk);
        slv_rlast_fire_i[1] = 1'b0;
        tests++;
        if (timeout_o !== 1'b0 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL timeout pulse width: tmo=%b err=%b want 0/0", timeout_o, err_o);
        end
    endtask

    task automatic test_ar_limit();
        slv_ar_fire_i[2] = 1'b1;
        for (int k = 1; k <= MAXO; k++) begin
            @(negedge clk);
            tests++;
            if (slv_ar_block_o[2] !== (k == MAXO) || slv_aw_block_o[2] !== 1'b0) begin
                fails++;
                $display("FAIL ar limit after %0d AR: arb=%b awb=%b want %b/0",
                         k, slv_ar_block_o[2], slv_aw_block_o[2], k == MAXO);
            end
        end
        slv_ar_fire_i[2] = 1'b0;
        slv_rlast_fire_i[2] = 1'b1;
        @(negedge clk);
        slv_rlast_fire_i[2] = 1'b0;
        tests++;
        if (slv_ar_block_o[2] !== 1'b0) begin
            fails++;
            $display("FAIL ar limit release: arb=%b want 0", slv_ar_block_o[2]);
        end
        slv_rlast_fire_i[2] = 1'b1;
        repeat (MAXO - 1) @(negedge clk);
        slv_rlast_fire_i[2] = 1'b0;
        tests++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL ar drain error: err=%b want 0", err_o);
        end
    endtask

    task automatic test_same_cycle_err();
        slv_aw_fire_i[1] = 1'b1;
        @(negedge clk);
        slv_b_fire_i[1] = 1'b1;
        @(negedge clk);
        slv_aw_fire_i[1] = 1'b0;
        @(negedge clk);
        slv_b_fire_i[1] = 1'b0;
        tests++;
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL same-cycle AW+B count: err=%b want 0", err_o);
        end
        slv_b_fire_i[1] = 1'b1;
        @(negedge clk);
        slv_b_fire_i[1] = 1'b0;
        tests++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL underflow flag: err=%b want 1", err_o);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL underflow sticky: err=%b want 1", err_o);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        logic t;
        for (int k = 0; k < 2; k++) begin
            send_req(0, 1, 32'h3000_0000, 32'h3FFF_FFFF, 1'b1, 1'b1, 1'b1);
            wait_sequence(n, t);
            tests++;
            if (n != 3 || t !== 1'b0 || req_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL back-to-back commit %0d: busy=%0d tmo=%b rdy=%b want 3/0/1", k, n, t, req_ready_o);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        slv_aw_fire_i[3] = 1'b1;
        @(negedge clk);
        slv_aw_fire_i[3] = 1'b0;
        send_req(1, 1, 32'h4000_0000, 32'h4FFF_FFFF, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_busy_cfg("drain held before reset");
        #2 rst_n = 1'b0;
        sh  = '0;
        act = '0;
        exp_q.delete();
        #1 check_reset_outputs("reset mid drain");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || cur_cfg() !== cfg_t'(0)) begin
            fails++;
            $display("FAIL after mid-drain reset: rdy=%b busy=%b cfgv=%h want 1/0/0", req_ready_o, busy_o, cfg_valid_rule_o);
        end
    endtask

    initial begin
        test_reset();
        test_shadow_commit();
        test_drain_aw();
        test_timeout();
        test_ar_limit();
        test_same_cycle_err();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
